// File: rtl/param_bank.sv
// Double-buffered fixed-point coefficient bank.
// Writes land in a shadow bank; a commit copies the whole shadow bank to the
// active bank on an integrator step boundary (sync_i), so consumers of
// params_o never observe a half-updated coefficient set.
//
// state | meaning
// IDLE  | shadow writable, no transfer armed
// PEND  | commit armed, shadow frozen, waiting for sync_i
module param_bank #(
  parameter int Width     = 32,
  parameter int Frac      = 21,
  parameter int NumParams = 8,
  parameter int AddrW     = 3,
  parameter logic [NumParams*Width-1:0] RstVals = {
    32'h0000_0000,  // spare
    32'h0003_3333,  // z0
    32'h0003_3333,  // y0
    32'h0003_3333,  // x0
    32'h0000_0831,  // h
    32'h00B6_6666,  // c
    32'h0006_6666,  // b
    32'h0006_6666   // a
  }
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [AddrW-1:0]           wr_addr_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       commit_i,
  input  logic                       revert_i,
  input  logic                       sync_i,
  output logic [NumParams*Width-1:0] params_o,
  output logic                       pend_o,
  output logic                       upd_o,
  output logic                       err_o
);

  localparam int BankW = NumParams * Width;
  localparam logic [AddrW:0] NumSlots = (AddrW + 1)'(NumParams);

  // Reject configurations whose slot count cannot be addressed or whose
  // fraction field does not fit in the word.
  if (NumParams > (2 ** AddrW) || Frac >= Width) begin : g_bad_cfg
    $error("param_bank: invalid NumParams/AddrW/Frac combination");
  end

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [BankW-1:0] shadow, shadow_nx, shadow_wr;
  logic [BankW-1:0] active, active_nx;
  logic             upd, upd_nx;
  logic             err, err_nx;
  logic             wr_fire, wr_in_range, wr_hit, wr_bad;

  // A write is taken only in IDLE, and a same-cycle revert discards it.
  assign wr_fire     = wr_valid_i && (state == IDLE) && !revert_i;
  assign wr_in_range = {1'b0, wr_addr_i} < NumSlots;
  assign wr_hit      = wr_fire && wr_in_range;
  assign wr_bad      = wr_fire && !wr_in_range;

  // Shadow bank as it looks with this cycle's write applied.
  always_comb begin
    shadow_wr = shadow;
    for (int k = 0; k < NumParams; k++) begin
      if (wr_hit && (wr_addr_i == k[AddrW-1:0])) begin
        shadow_wr[k*Width +: Width] = wr_data_i;
      end
    end
  end

  // Next-state, bank transfer and flag logic.
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    active_nx = active;
    upd_nx    = 1'b0;
    err_nx    = err;
    case (state)
      IDLE: begin
        if (revert_i) begin
          shadow_nx = active;
        end else begin
          shadow_nx = shadow_wr;
          if (commit_i) begin
            // Commit clears the sticky error, but a bad write in the same
            // cycle still leaves it set.
            err_nx = wr_bad;
            if (sync_i) begin
              active_nx = shadow_wr;
              upd_nx    = 1'b1;
            end else begin
              state_nx = PEND;
            end
          end else begin
            err_nx = err | wr_bad;
          end
        end
      end
      PEND: begin
        if (revert_i) begin
          shadow_nx = active;
          state_nx  = IDLE;
        end else if (sync_i) begin
          active_nx = shadow;
          upd_nx    = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, banks and flags; reset restores both banks to RstVals.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      shadow <= RstVals;
      active <= RstVals;
      upd    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      active <= active_nx;
      upd    <= upd_nx;
      err    <= err_nx;
    end
  end

  assign params_o   = active;
  assign pend_o     = (state == PEND);
  assign wr_ready_o = (state == IDLE);
  assign upd_o      = upd;
  assign err_o      = err;

endmodule

// File: tb/tb_param_bank.sv
// Bench for param_bank: two instances (8 slots and 7 slots) share one
// stimulus stream; each is compared every cycle with a slot-array model.
module tb_param_bank;

  localparam logic [255:0] RV = {
    32'h0000_0000, 32'h0003_3333, 32'h0003_3333, 32'h0003_3333,
    32'h0000_0831, 32'h00B6_6666, 32'h0006_6666, 32'h0006_6666
  };

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         wr_valid = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         commit = 1'b0;
  logic         revert = 1'b0;
  logic         sync = 1'b0;

  logic         rdy8, pend8, upd8, err8;
  logic         rdy7, pend7, upd7, err7;
  logic [255:0] p8;
  logic [223:0] p7;

  int n_cmp = 0;
  int n_bad = 0;

  // model: index 0 = 8-slot instance, 1 = 7-slot instance
  logic [31:0] m_act [2][8];
  logic [31:0] m_sh  [2][8];
  logic        m_pend[2];
  logic        m_upd [2];
  logic        m_err [2];

  always #5 clk = ~clk;

  param_bank dut8 (
    .clk_i(clk), .rst_i(rst_i), .wr_valid_i(wr_valid), .wr_ready_o(rdy8),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit),
    .revert_i(revert), .sync_i(sync), .params_o(p8), .pend_o(pend8),
    .upd_o(upd8), .err_o(err8)
  );

  param_bank #(.NumParams(7), .RstVals(RV[223:0])) dut7 (
    .clk_i(clk), .rst_i(rst_i), .wr_valid_i(wr_valid), .wr_ready_o(rdy7),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit),
    .revert_i(revert), .sync_i(sync), .params_o(p7), .pend_o(pend7),
    .upd_o(upd7), .err_o(err7)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        m_act[d][k] = (d == 1 && k == 7) ? 32'h0 : RV[k*32 +: 32];
        m_sh[d][k]  = m_act[d][k];
      end
      m_pend[d] = 1'b0;
      m_upd[d]  = 1'b0;
      m_err[d]  = 1'b0;
    end
  endtask

  // One clock edge of the behaviour, computed from the current inputs.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int  n;
      logic bad;
      n = (d == 0) ? 8 : 7;
      m_upd[d] = 1'b0;
      if (m_pend[d]) begin
        if (revert) begin
          m_sh[d] = m_act[d];
          m_pend[d] = 1'b0;
        end else if (sync) begin
          m_act[d] = m_sh[d];
          m_pend[d] = 1'b0;
          m_upd[d] = 1'b1;
        end
      end else if (revert) begin
        m_sh[d] = m_act[d];
      end else begin
        bad = 1'b0;
        if (wr_valid) begin
          if (int'(wr_addr) < n) m_sh[d][wr_addr] = wr_data;
          else bad = 1'b1;
        end
        if (commit) begin
          m_err[d] = bad;
          if (sync) begin
            m_act[d] = m_sh[d];
            m_upd[d] = 1'b1;
          end else begin
            m_pend[d] = 1'b1;
          end
        end else begin
          m_err[d] = m_err[d] | bad;
        end
      end
    end
  endtask

  function automatic logic [255:0] mpack(input int d);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = m_act[d][k];
    return r;
  endfunction

  task automatic check_all();
    check("params8", p8, mpack(0));
    check("pend8", 256'(pend8), 256'(m_pend[0]));
    check("upd8", 256'(upd8), 256'(m_upd[0]));
    check("err8", 256'(err8), 256'(m_err[0]));
    check("ready8", 256'(rdy8), 256'(!m_pend[0]));
    check("params7", {32'h0, p7}, mpack(1));
    check("pend7", 256'(pend7), 256'(m_pend[1]));
    check("upd7", 256'(upd7), 256'(m_upd[1]));
    check("err7", 256'(err7), 256'(m_err[1]));
    check("ready7", 256'(rdy7), 256'(!m_pend[1]));
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [31:0] dat,
                       input logic c, input logic r, input logic s);
    wr_valid = v; wr_addr = a; wr_data = dat; commit = c; revert = r; sync = s;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [223:0] p7_before;

    // reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_i = 1'b0;
    check("rst_slot0", 256'(p8[0 +: 32]), 256'(32'h0006_6666));
    check("rst_slot2", 256'(p8[64 +: 32]), 256'(32'h00B6_6666));
    check("rst_slot3", 256'(p8[96 +: 32]), 256'(32'h0000_0831));
    check("rst_pend", 256'(pend8), 256'(1'b0));
    check("rst_ready", 256'(rdy8), 256'(1'b1));

    // write slot2, commit, hold off sync for 5 cycles
    drive(1, 3'd2, 32'h00A0_0000, 0, 0, 0); cyc();
    drive(0, 3'd0, 32'h0, 1, 0, 0); cyc();
    drive(0, 3'd0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_slot2", 256'(p8[64 +: 32]), 256'(32'h00B6_6666));
      check("hold_pend", 256'(pend8), 256'(1'b1));
      check("hold_ready", 256'(rdy8), 256'(1'b0));
    end
    drive(0, 3'd0, 32'h0, 0, 0, 1); cyc();
    check("sync_slot2", 256'(p8[64 +: 32]), 256'(32'h00A0_0000));
    check("sync_upd", 256'(upd8), 256'(1'b1));
    drive(0, 3'd0, 32'h0, 0, 0, 0); cyc();
    check("upd_one_cycle", 256'(upd8), 256'(1'b0));

    // write + commit + sync in the same IDLE cycle
    drive(1, 3'd0, 32'h0008_0000, 1, 0, 1); cyc();
    check("fast_slot0", 256'(p8[0 +: 32]), 256'(32'h0008_0000));
    check("fast_pend", 256'(pend8), 256'(1'b0));
    check("fast_upd", 256'(upd8), 256'(1'b1));

    // out-of-range write on the 7-slot instance
    drive(0, 3'd0, 32'h0, 0, 0, 0); cyc();
    p7_before = p7;
    drive(1, 3'd7, 32'h1234_5678, 0, 0, 0); cyc();
    check("oor_err", 256'(err7), 256'(1'b1));
    check("oor_params", {32'h0, p7}, {32'h0, p7_before});
    drive(0, 3'd0, 32'h0, 1, 0, 0); cyc();
    check("oor_err_clear", 256'(err7), 256'(1'b0));
    drive(0, 3'd0, 32'h0, 0, 0, 1); cyc();
    check("oor_after_sync", {32'h0, p7}, {32'h0, p7_before});

    // revert discards a shadow edit
    drive(1, 3'd1, 32'h0010_0000, 0, 0, 0); cyc();
    drive(0, 3'd0, 32'h0, 0, 1, 0); cyc();
    drive(0, 3'd0, 32'h0, 1, 0, 1); cyc();
    check("revert_slot1", 256'(p8[32 +: 32]), 256'(32'h0006_6666));

    // reset in PEND drops the commit
    drive(1, 3'd4, 32'h0077_0000, 1, 0, 0); cyc();
    check("pre_rst_pend", 256'(pend8), 256'(1'b1));
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check("async_rst_params", p8, RV);
    check("async_rst_pend", 256'(pend8), 256'(1'b0));
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    drive(0, 3'd0, 32'h0, 0, 0, 1); cyc();
    check("rst_pend_params", p8, RV);
    check("rst_pend_upd", 256'(upd8), 256'(1'b0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_i = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_all();
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
